// File: rtl/acc_pkg.sv
// acc_pkg: shared FSM state, tag FIFO entry type and round-robin pick for acc_share_arbiter
//   MAX_REQ / IDX_W : widest supported requester count and its index width
//   arb_state_t     : feed FSM states
//   tag_entry_t     : owner index plus output beat count of one in-flight job
//   rr_pick         : first valid index at or after ptr, wrapping within n requesters
package acc_pkg;
  localparam int MAX_REQ = 8;
  localparam int IDX_W = $clog2(MAX_REQ);
  typedef enum logic {S_IDLE, S_FEED} arb_state_t;
  typedef struct packed {
    logic [IDX_W-1:0] req_idx;
    logic [15:0]      dratio;
  } tag_entry_t;
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid, input logic [IDX_W-1:0] ptr, input int n);
    logic [IDX_W-1:0] r;
    int j;
    r = ptr;
    // scanning from the far end lets the nearest valid index after ptr win
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % n;
      if (i < n && valid[j[IDX_W-1:0]]) r = j[IDX_W-1:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/acc_tag_fifo.sv
// acc_tag_fifo: in-order FIFO of job ownership tags
//   clk, rst_n (sync, active-low); push/din write, pop retires head;
//   head is the oldest entry, full/empty reflect the current count
module acc_tag_fifo import acc_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  tag_entry_t din,
  input  logic       pop,
  output tag_entry_t head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  tag_entry_t mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  always_comb begin
    full = cnt == (AW+1)'(DEPTH);
    empty = cnt == '0;
    do_push = push & !full;
    do_pop = pop & !empty;
    head = mem[rd];
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= do_push ? wr + AW'(1) : wr;
      rd <= do_pop ? rd + AW'(1) : rd;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/acc_share_arbiter.sv
// acc_share_arbiter: round-robin sharing of one accelerator between NUM_REQ streams
//   clk, rst_n (sync, active-low); ser_ratio/deser_ratio beats per job, sampled at grant
//   req_*  : requester input beats       acc_in_*  : beats to the accelerator
//   acc_out_* : accelerator results      rsp_*     : results routed to the owning requester
//   busy : feeding or jobs in flight     err_orphan : sticky, result seen with no job in flight
//   ACC_ARB_PERF_CNT_EN adds job_done_cnt (per-requester completed jobs) and stall_cnt
//   (cycles a request waits on a full tag FIFO)
module acc_share_arbiter import acc_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 64,
  parameter int TAG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef ACC_ARB_PERF_CNT_EN
  output logic [NUM_REQ*32-1:0]     job_done_cnt,
  output logic [31:0]               stall_cnt,
`endif
  input  logic [15:0]               ser_ratio,
  input  logic [15:0]               deser_ratio,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      acc_in_valid,
  output logic [DATA_W-1:0]         acc_in_data,
  input  logic                      acc_in_ready,
  input  logic                      acc_out_valid,
  input  logic [DATA_W-1:0]         acc_out_data,
  output logic                      acc_out_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      busy,
  output logic                      err_orphan
);
  localparam int GW = $clog2(NUM_REQ);
  arb_state_t state;
  logic [GW-1:0] grant, rr_ptr, pick, head_idx;
  logic [15:0] ser_l, in_cnt, out_cnt, ser_eff, deser_eff;
  tag_entry_t head, push_entry;
  logic full, empty, feed, start, in_hs, out_hs, last_in, pop;
  always_comb begin
    ser_eff = ser_ratio == '0 ? 16'd1 : ser_ratio;
    deser_eff = deser_ratio == '0 ? 16'd1 : deser_ratio;
    feed = state == S_FEED;
    start = !feed && |req_valid && !full;
    pick = GW'(rr_pick(MAX_REQ'(req_valid), IDX_W'(rr_ptr), NUM_REQ));
    push_entry = '{req_idx: IDX_W'(pick), dratio: deser_eff};
    acc_in_valid = feed & req_valid[grant];
    acc_in_data = feed ? req_data[grant*DATA_W +: DATA_W] : '0;
    req_ready = feed ? NUM_REQ'(acc_in_ready) << grant : '0;
    in_hs = acc_in_valid & acc_in_ready;
    last_in = in_cnt == ser_l - 16'd1;
    head_idx = head.req_idx[GW-1:0];
    rsp_valid = empty ? '0 : NUM_REQ'(acc_out_valid) << head_idx;
    rsp_data = empty ? '0 : acc_out_data;
    acc_out_ready = !empty & rsp_ready[head_idx];
    out_hs = acc_out_valid & acc_out_ready;
    pop = out_hs && out_cnt == head.dratio - 16'd1;
    busy = feed | !empty;
  end
  // full is the pre-pop count, so a pop in the same cycle never makes room for a push
  acc_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk(clk), .rst_n(rst_n), .push(start), .din(push_entry),
    .pop(pop), .head(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      grant <= '0;
      rr_ptr <= '0;
      ser_l <= '0;
      in_cnt <= '0;
      out_cnt <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (start) begin
        state <= S_FEED;
        grant <= pick;
        ser_l <= ser_eff;
        rr_ptr <= pick == GW'(NUM_REQ - 1) ? '0 : pick + GW'(1);
      end else if (in_hs) begin
        state <= last_in ? S_IDLE : S_FEED;
        in_cnt <= last_in ? '0 : in_cnt + 16'd1;
      end
      if (out_hs) out_cnt <= pop ? '0 : out_cnt + 16'd1;
      err_orphan <= err_orphan | (empty & acc_out_valid);
    end
`ifdef ACC_ARB_PERF_CNT_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      job_done_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) job_done_cnt[head_idx*32 +: 32] <= job_done_cnt[head_idx*32 +: 32] + 32'd1;
      if (!feed && |req_valid && full) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_acc_share_arbiter.sv
// tb_acc_share_arbiter: directed self-checking bench for acc_share_arbiter
module tb_acc_share_arbiter;
  localparam int N = 4;
  localparam int W = 64;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] ser_ratio, deser_ratio;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_data;
  logic acc_in_valid, acc_in_ready, acc_out_valid, acc_out_ready, busy, err_orphan;
  logic [W-1:0] acc_in_data, acc_out_data, rsp_data;
`ifdef ACC_ARB_PERF_CNT_EN
  logic [N*32-1:0] job_done_cnt;
  logic [31:0] stall_cnt;
`endif
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  acc_share_arbiter #(.NUM_REQ(N), .DATA_W(W), .TAG_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ACC_ARB_PERF_CNT_EN
    .job_done_cnt(job_done_cnt), .stall_cnt(stall_cnt),
`endif
    .ser_ratio(ser_ratio), .deser_ratio(deser_ratio),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .acc_in_valid(acc_in_valid), .acc_in_data(acc_in_data), .acc_in_ready(acc_in_ready),
    .acc_out_valid(acc_out_valid), .acc_out_data(acc_out_data), .acc_out_ready(acc_out_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .err_orphan(err_orphan)
  );
  task step;
    @(posedge clk);
    #1;
  endtask
  task idle_inputs;
    ser_ratio = 16'd1;
    deser_ratio = 16'd1;
    req_valid = '0;
    acc_in_ready = 1'b1;
    acc_out_valid = 1'b0;
    acc_out_data = '0;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 64'h1000 + 64'(i);
  endtask
  task do_reset;
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask
  task test_reset;
    rst_n = 1'b0;
    idle_inputs();
    req_valid = '1;
    acc_out_valid = 1'b1;
    acc_out_data = 64'hDEAD;
    step();
    step();
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (acc_in_valid !== 1'b0) begin errors++; $display("FAIL reset_acc_in_valid: got %b expected 0", acc_in_valid); end
    checks++; if (acc_in_data !== 64'h0) begin errors++; $display("FAIL reset_acc_in_data: got %h expected 0", acc_in_data); end
    checks++; if (acc_out_ready !== 1'b0) begin errors++; $display("FAIL reset_acc_out_ready: got %b expected 0", acc_out_ready); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_data !== 64'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan: got %b expected 0", err_orphan); end
    idle_inputs();
    step();
    rst_n = 1'b1;
  endtask
  task test_single;
    do_reset();
    ser_ratio = 16'd2;
    req_valid = 4'b0100;
    req_data[2*W +: W] = 64'hA1;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL single_idle_ready: got %b expected 0000", req_ready); end
    step();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
    checks++; if (acc_in_valid !== 1'b1) begin errors++; $display("FAIL single_in_valid: got %b expected 1", acc_in_valid); end
    checks++; if (acc_in_data !== 64'hA1) begin errors++; $display("FAIL single_in_data1: got %h expected a1", acc_in_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_feed: got %b expected 1", busy); end
    req_data[2*W +: W] = 64'hA2;
    step();
    checks++; if (acc_in_data !== 64'hA2 || req_ready !== 4'b0100) begin errors++; $display("FAIL single_beat2: got data %h ready %b expected a2 0100", acc_in_data, req_ready); end
    step();
    req_valid = '0;
    acc_out_valid = 1'b1;
    acc_out_data = 64'hBEEF;
    #1;
    checks++; if (acc_in_valid !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL single_back_idle: got valid %b ready %b expected 0 0000", acc_in_valid, req_ready); end
    checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_rsp_route: got %b expected 0100", rsp_valid); end
    checks++; if (rsp_data !== 64'hBEEF) begin errors++; $display("FAIL single_rsp_data: got %h expected beef", rsp_data); end
    checks++; if (acc_out_ready !== 1'b1) begin errors++; $display("FAIL single_out_ready: got %b expected 1", acc_out_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_tag: got %b expected 1", busy); end
    step();
    acc_out_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0) begin errors++; $display("FAIL single_after_pop: got busy %b rsp %b expected 0 0000", busy, rsp_valid); end
  endtask
  task test_round_robin;
    int jobs, res, cyc;
    int q[$];
    jobs = 0;
    res = 0;
    cyc = 0;
    do_reset();
    req_valid = 4'b1111;
    while ((jobs < 5 || res < 5) && cyc < 80) begin
      acc_out_valid = q.size() > 0;
      acc_out_data = 64'hA000 + 64'(res);
      #1;
      if (acc_in_valid && acc_in_ready) begin
        checks++; if (req_ready !== (4'b0001 << (jobs % 4))) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", jobs, req_ready, 4'b0001 << (jobs % 4)); end
        checks++; if (acc_in_data !== 64'h1000 + 64'(jobs % 4)) begin errors++; $display("FAIL rr_in_data%0d: got %h expected %h", jobs, acc_in_data, 64'h1000 + 64'(jobs % 4)); end
        q.push_back(jobs % 4);
        jobs++;
        if (jobs == 5) req_valid = '0;
      end
      if (acc_out_valid) begin
        checks++; if (rsp_valid !== (4'b0001 << q[0]) || acc_out_ready !== 1'b1 || rsp_data !== 64'hA000 + 64'(res)) begin errors++; $display("FAIL rr_rsp%0d: got valid %b ready %b data %h expected %b 1 %h", res, rsp_valid, acc_out_ready, rsp_data, 4'b0001 << q[0], 64'hA000 + 64'(res)); end
        q.pop_front();
        res++;
      end
      step();
      cyc++;
    end
    acc_out_valid = 1'b0;
    checks++; if (jobs != 5 || res != 5) begin errors++; $display("FAIL rr_complete: got jobs %0d results %0d expected 5 5", jobs, res); end
  endtask
  task test_full;
    int hs, blocked;
`ifdef ACC_ARB_PERF_CNT_EN
    logic [31:0] s0;
    s0 = '0;
`endif
    hs = 0;
    blocked = 0;
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (acc_in_valid && acc_in_ready) hs++;
      if (i >= 8 && req_ready !== 4'b0) blocked++;
`ifdef ACC_ARB_PERF_CNT_EN
      if (i == 8) s0 = stall_cnt;
`endif
      step();
    end
    #1;
    checks++; if (hs != 4) begin errors++; $display("FAIL full_jobs: got %0d expected 4", hs); end
    checks++; if (blocked != 0) begin errors++; $display("FAIL full_blocked: got %0d ready cycles expected 0", blocked); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", busy); end
`ifdef ACC_ARB_PERF_CNT_EN
    checks++; if (stall_cnt - s0 !== 32'd4) begin errors++; $display("FAIL full_stall_cnt: got %0d expected 4", stall_cnt - s0); end
`endif
    acc_out_valid = 1'b1;
    acc_out_data = 64'h55;
    #1;
    checks++; if (rsp_valid !== 4'b0001 || acc_out_ready !== 1'b1 || req_ready !== 4'b0) begin errors++; $display("FAIL full_release: got rsp %b ready %b req_ready %b expected 0001 1 0000", rsp_valid, acc_out_ready, req_ready); end
    step();
    acc_out_valid = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL full_no_same_cycle: got %b expected 0000", req_ready); end
    step();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL full_next_grant: got %b expected 0001", req_ready); end
  endtask
  task test_ratio;
    int n;
    n = 0;
    do_reset();
    ser_ratio = 16'd0;
    deser_ratio = 16'd0;
    req_valid = 4'b0010;
    step();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ratio0_grant: got %b expected 0010", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if (req_ready !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL ratio0_one_beat: got ready %b busy %b expected 0000 1", req_ready, busy); end
    acc_out_valid = 1'b1;
    #1;
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL ratio0_rsp: got %b expected 0010", rsp_valid); end
    step();
    acc_out_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ratio0_one_result: got busy %b expected 0", busy); end
    ser_ratio = 16'd1;
    deser_ratio = 16'd3;
    req_valid = 4'b0010;
    step();
    ser_ratio = 16'd9;
    deser_ratio = 16'd7;
    step();
    req_valid = '0;
    #1;
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL ratio_latched_ser: got %b expected 0000", req_ready); end
    for (int i = 0; i < 5; i++) begin
      acc_out_valid = 1'b1;
      rsp_ready = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      #1;
      if (acc_out_valid && acc_out_ready) n++;
      step();
    end
    acc_out_valid = 1'b0;
    rsp_ready = '1;
    #1;
    checks++; if (n != 3) begin errors++; $display("FAIL deser3_handshakes: got %0d expected 3", n); end
    checks++; if (busy !== 1'b0 || err_orphan !== 1'b0) begin errors++; $display("FAIL deser3_pop: got busy %b orphan %b expected 0 0", busy, err_orphan); end
  endtask
  task test_orphan_reset;
    do_reset();
    acc_out_valid = 1'b1;
    #1;
    checks++; if (acc_out_ready !== 1'b0 || rsp_valid !== 4'b0) begin errors++; $display("FAIL orphan_gate: got ready %b rsp %b expected 0 0000", acc_out_ready, rsp_valid); end
    step();
    acc_out_valid = 1'b0;
    #1;
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set: got %b expected 1", err_orphan); end
    step();
    step();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b expected 1", err_orphan); end
    ser_ratio = 16'd4;
    req_valid = 4'b0001;
    step();
    step();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midjob_feeding: got %b expected 0001", req_ready); end
    rst_n = 1'b0;
    step();
    checks++; if (req_ready !== 4'b0 || acc_in_valid !== 1'b0 || busy !== 1'b0 || err_orphan !== 1'b0 || acc_out_ready !== 1'b0) begin errors++; $display("FAIL midjob_reset: got ready %b in_valid %b busy %b orphan %b out_ready %b expected all 0", req_ready, acc_in_valid, busy, err_orphan, acc_out_ready); end
    rst_n = 1'b1;
    req_valid = '0;
    acc_out_valid = 1'b1;
    #1;
    checks++; if (acc_out_ready !== 1'b0 || rsp_valid !== 4'b0) begin errors++; $display("FAIL midjob_fifo_empty: got ready %b rsp %b expected 0 0000", acc_out_ready, rsp_valid); end
    acc_out_valid = 1'b0;
  endtask
`ifdef ACC_ARB_PERF_CNT_EN
  task test_perf;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      req_valid = (j < 3) ? 4'b0010 : 4'b1000;
      step();
      step();
      req_valid = '0;
      acc_out_valid = 1'b1;
      step();
      acc_out_valid = 1'b0;
    end
    #1;
    checks++; if (job_done_cnt !== {32'd2, 32'd0, 32'd3, 32'd0}) begin errors++; $display("FAIL perf_job_done: got %h expected %h", job_done_cnt, {32'd2, 32'd0, 32'd3, 32'd0}); end
  endtask
`endif
  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_ratio();
    test_orphan_reset();
`ifdef ACC_ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
